// File: rtl/cpu_pkg.sv
// Types and widths shared between the CPU core and its program-memory loader.
package cpu_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single pad input; both stages clear to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory for the CPU: serially loaded from pads while the CPU is held in
// reset, then served to the CPU fetch port with a one-cycle registered read.
module prog_mem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              ld_sclk,
  input  logic              ld_sdata,
  input  logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_ovf,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [2:0] pad_raw;
  logic [2:0] pad_sync;
  logic       ld_en_s;
  logic       sclk_s;
  logic       sdata_s;

  assign pad_raw = {ld_en, ld_sclk, ld_sdata};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pad_raw[gi]),
      .q   (pad_sync[gi])
    );
  end

  assign ld_en_s = pad_sync[2];
  assign sclk_s  = pad_sync[1];
  assign sdata_s = pad_sync[0];

  state_t             state_reg, state_next;
  logic               sclk_d_reg;
  logic [DATA_W-1:0]  shift_reg, shift_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic               load_ovf_reg, load_ovf_next;
  logic               load_done_reg, load_done_next;
  logic               cpu_rst_reg;
  logic [DATA_W-1:0]  data_bus_reg;
  logic               sclk_rise;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;

  logic [DATA_W-1:0]  mem [DEPTH];

  assign sclk_rise = sclk_s & ~sclk_d_reg;

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    load_ovf_next  = load_ovf_reg;
    load_done_next = load_done_reg;
    mem_we         = 1'b0;
    mem_wdata      = {shift_reg[DATA_W-2:0], sdata_s};

    case (state_reg)
      IDLE, RUN: begin
        if (ld_en_s) begin
          state_next    = LOAD;
          shift_next    = '0;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          load_ovf_next = 1'b0;
        end else begin
          state_next = RUN;
        end
      end
      LOAD: begin
        if (sclk_rise) begin
          shift_next = mem_wdata;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            // A full memory drops the byte and flags it instead of wrapping.
            if (byte_cnt_reg == FULL_CNT) begin
              load_ovf_next = 1'b1;
            end else begin
              mem_we        = 1'b1;
              byte_cnt_next = byte_cnt_reg + 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        if (!ld_en_s) begin
          state_next     = RUN;
          load_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sclk_d_reg    <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      load_ovf_reg  <= 1'b0;
      load_done_reg <= 1'b0;
      cpu_rst_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      sclk_d_reg    <= sclk_s;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      load_ovf_reg  <= load_ovf_next;
      load_done_reg <= load_done_next;
      // Released one cycle after RUN is entered, so the first fetch sees settled memory.
      cpu_rst_reg   <= (state_reg != RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[byte_cnt_reg[ADDR_W-1:0]] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_bus_reg <= '0;
    end else if (state_reg == RUN) begin
      data_bus_reg <= mem[addr_bus];
    end else begin
      data_bus_reg <= '0;
    end
  end

  assign data_bus  = data_bus_reg;
  assign cpu_rst   = cpu_rst_reg;
  assign load_done = load_done_reg;
  assign load_ovf  = load_ovf_reg;
  assign byte_cnt  = byte_cnt_reg;

endmodule
